reflet_int_controller: RTL

Memory-mapped interrupt controller that consumes the interrupt pulses of reflet_timer_2, reflet_timer and the other peripherals. It sits between those peripherals and the CPU.
- Latches each input event as a pending bit.
- Masks pending bits with an enable register.
- Picks the highest-priority pending source and presents one request to the CPU.
- Tracks that request through acknowledge and end-of-interrupt.

---
 rtl/reflet_int_controller_pkg.sv | 17 +
 rtl/reflet_priority_enc.sv | 19 +
 rtl/reflet_rw_register.sv | 25 ++
 rtl/reflet_int_controller.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/reflet_int_controller_pkg.sv
// rtl/reflet_int_controller_pkg.sv - shared register offsets, FSM encoding and limits
package reflet_int_controller_pkg;

   localparam int NB_INT_MAX = 8;

   localparam logic [1:0] REG_MASK    = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_EOI     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/reflet_priority_enc.sv
// rtl/reflet_priority_enc.sv - lowest-set-index encoder, returns {valid, index}
module reflet_priority_enc #(
   parameter int width = 4
) (
   input  logic [width-1:0] vec,
   output logic [3:0]       result
);

   always_comb begin
      result = 4'h0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = width - 1; i >= 0; i--) begin
         if (vec[i]) begin
            result = {1'b1, 3'(i)};
         end
      end
   end

endmodule

// File: rtl/reflet_rw_register.sv
// rtl/reflet_rw_register.sv - generic read/write register at one bus offset
module reflet_rw_register #(
   parameter int                     addr_size     = 2,
   parameter logic [addr_size-1:0]   reg_addr      = '0,
   parameter int                     width         = 8,
   parameter logic [width-1:0]       default_value = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [addr_size-1:0] addr,
   input  logic                 write_en,
   input  logic [width-1:0]     data_in,
   output logic [width-1:0]     content
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         content <= default_value;
      end else if (enable && write_en && addr == reg_addr) begin
         content <= data_in;
      end
   end

endmodule

// File: rtl/reflet_int_controller.sv
// rtl/reflet_int_controller.sv - edge-latched, masked, priority interrupt controller
module reflet_int_controller
   import reflet_int_controller_pkg::*;
#(
   parameter int                        base_addr_size = 16,
   parameter logic [base_addr_size-1:0] base_addr      = 16'hFF20,
   parameter int                        nb_int         = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [base_addr_size-1:0] addr,
   input  logic                      write_en,
   input  logic [7:0]                data_in,
   output logic [7:0]                data_out,
   input  logic [nb_int-1:0]         int_in,
   output logic                      cpu_int,
   output logic [2:0]                cpu_int_num,
   input  logic                      cpu_ack
);

   localparam logic [base_addr_size:0] addr_lo = {1'b0, base_addr};
   localparam logic [base_addr_size:0] addr_hi = addr_lo + (base_addr_size + 1)'(4);

   state_t            state;
   logic              sel, wr, rd;
   logic [1:0]        offset;
   logic [nb_int-1:0] mask, mask_next, pending, pending_next, int_prev;
   logic [nb_int-1:0] edges, sw_clear, ack_clear, num_onehot, eligible;
   logic [3:0]        winner;
   logic              ack_take, eoi_take, withdraw;
   logic [7:0]        mask8, pend8, rdata;
   logic              unused_data_in;

   assign sel    = enable && ({1'b0, addr} >= addr_lo) && ({1'b0, addr} < addr_hi);
   assign offset = 2'(addr - base_addr);
   assign wr     = sel && write_en;
   assign rd     = sel && !write_en;
   assign unused_data_in = ^data_in;

   reflet_rw_register #(
      .addr_size    (2),
      .reg_addr     (REG_MASK),
      .width        (nb_int),
      .default_value('0)
   ) u_mask (
      .clk     (clk),
      .reset   (reset),
      .enable  (sel),
      .addr    (offset),
      .write_en(write_en),
      .data_in (data_in[nb_int-1:0]),
      .content (mask)
   );

   always_comb begin
      num_onehot = '0;
      for (int i = 0; i < nb_int; i++) begin
         num_onehot[i] = (cpu_int_num == 3'(i));
      end
   end

   assign edges        = int_in & ~int_prev;
   assign ack_take     = (state == ST_REQUEST) && cpu_ack;
   assign eoi_take     = (state == ST_SERVICE) && wr && (offset == REG_EOI);
   assign sw_clear     = (wr && offset == REG_PENDING) ? data_in[nb_int-1:0] : '0;
   assign ack_clear    = ack_take ? num_onehot : '0;
   assign mask_next    = (wr && offset == REG_MASK) ? data_in[nb_int-1:0] : mask;
   // New edges are OR-ed last so they win over both software and ack clears.
   assign pending_next = (pending & ~sw_clear & ~ack_clear) | edges;
   // Withdraw in the same cycle software removes the request, not one later.
   assign withdraw     = ~|(pending_next & mask_next & num_onehot);
   assign eligible     = pending & mask;

   reflet_priority_enc #(.width(nb_int)) u_enc (
      .vec   (eligible),
      .result(winner)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending  <= '0;
         int_prev <= '0;
      end else begin
         pending  <= pending_next;
         int_prev <= int_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cpu_int     <= 1'b0;
         cpu_int_num <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winner[3]) begin
                  state       <= ST_REQUEST;
                  cpu_int     <= 1'b1;
                  cpu_int_num <= winner[2:0];
               end else begin
                  cpu_int <= 1'b0;
               end
            end
            ST_REQUEST: begin
               if (cpu_ack) begin
                  state   <= ST_SERVICE;
                  cpu_int <= 1'b0;
               end else if (withdraw) begin
                  state   <= ST_IDLE;
                  cpu_int <= 1'b0;
               end
            end
            ST_SERVICE: begin
               cpu_int <= 1'b0;
               if (eoi_take) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               cpu_int <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      mask8 = '0;
      pend8 = '0;
      mask8[nb_int-1:0] = mask;
      pend8[nb_int-1:0] = pending;
      case (offset)
         REG_MASK:    rdata = mask8;
         REG_PENDING: rdata = pend8;
         REG_STATUS:  rdata = {state, 3'b000, cpu_int_num};
         default:     rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out <= 8'h00;
      end else begin
         data_out <= rd ? rdata : 8'h00;
      end
   end

endmodule
